i2c_slave_regs: RTL and testbench
=================================

Name: i2c_slave_regs

Overview:
- Synthesizable I2C target (slave) responder: the other end of the team's I2C master driver.
- Oversamples SCL/SDA on the system clock and decodes START, STOP and repeated START.
- Matches a 7-bit device address and drives ACK and read data open-drain.
- Exposes a simple byte-wide register port (pointer write, then auto-incrementing data writes and reads), EEPROM style, so the master can be exercised on-board or in the top-level bench.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit device address to respond to.
- AW, 8, register pointer width; the pointer wraps modulo 2^AW.

Ports:
- clk  input  1  system clock, 50 MHz nominal; must be ≥ 20× the SCL frequency.
- rstn  input  1  asynchronous active-low reset.
- scl_i  input  1  SCL line level (asynchronous).
- sda_i  input  1  SDA line level (asynchronous).
- sda_oe  output  1  1 = pull SDA low; 0 = release. The top level builds the tristate: sda = sda_oe ? 0 : z.
- reg_addr  output  AW  current register pointer.
- reg_wr  output  1  one-clk write strobe.
- reg_wdata  output  8  write data, valid while reg_wr = 1.
- reg_rd  output  1  one-clk strobe; reg_rdata is sampled on this cycle.
- reg_rdata  input  8  read data for reg_addr; combinational from the user side.
- busy  output  1  high from an address-matched START until STOP, NACK or mismatch.

Behaviour:
- Reset values: sda_oe=0, reg_addr=0, reg_wr=0, reg_wdata=0, reg_rd=0, busy=0, state=IDLE. Reset mid-transfer releases SDA immediately (asynchronous).
- Synchronisation: scl_i and sda_i each pass through a 2-FF synchronizer plus one history FF.
  - Edge and condition detection uses the synced and history values.
  - A bus event becomes visible 3 clks after the pin changes.
- Conditions:
  - START = synced SDA 1→0 while synced SCL=1.
  - STOP = synced SDA 0→1 while synced SCL=1.
  - Both are recognised in every state and take priority over bit processing.
  - START (including repeated START) → ADDR, bit counter cleared, sda_oe=0.
  - STOP → IDLE, busy=0, sda_oe=0.
- Sampling and driving: bits are sampled on the synced SCL rising edge. sda_oe changes only on the clk following a synced SCL falling edge.
- States:
  - IDLE: ignore the bus until START.
  - ADDR: shift 8 bits MSB first. After bit 8:
    - If addr[7:1] == SLAVE_ADDR: ADDR_ACK, busy=1, latch the R/W bit.
    - Otherwise: IGNORE (no ACK, wait for START/STOP).
  - ADDR_ACK: drive sda_oe=1 from the falling edge after bit 8 to the falling edge after bit 9. Then:
    - If R/W=0: WR_BYTE, with first_byte flag set.
    - If R/W=1: assert reg_rd for 1 clk, load the shift register from reg_rdata, go to RD_BYTE.
  - WR_BYTE: shift 8 bits. On the 8th rising edge:
    - If first_byte: reg_addr ← byte, clear first_byte.
    - Otherwise: reg_wdata ← byte, reg_wr=1 for exactly 1 clk, then reg_addr increments on the next clk.
    - Then WR_ACK.
  - WR_ACK: ACK driven exactly as in ADDR_ACK, then WR_BYTE. The target always ACKs writes.
  - RD_BYTE:
    - On each falling edge: sda_oe = ~shift[7], shift left.
    - The MSB is driven at the falling edge that ends the preceding ACK.
    - After the 8th bit's falling edge: release SDA, increment reg_addr, go to RD_ACK.
  - RD_ACK: sample the master bit on the 9th rising edge.
    - 0 (ACK): on the following falling edge pulse reg_rd, reload the shift register, drive the MSB, go to RD_BYTE.
    - 1 (NACK): IGNORE, busy=0, SDA released.
- Wrap-around: reg_addr at 2^AW-1 increments to 0.
- Pointer retention: reg_addr is kept across transactions. A read without a preceding pointer write uses the last pointer.
- Repeated START after a pointer write (write-then-read) keeps the pointer.
- START arriving mid-byte or mid-ACK aborts the byte (no reg_wr) and releases SDA the same clk.
- SDA glitches while SCL is high are treated as conditions. No extra filtering beyond the synchronizer.

Test Plan:
- Write: START, 0xA0, 0x10, 0x5A, 0xC3, STOP (100 kHz SCL, 50 MHz clk) → ACK on all 4 bytes; reg_wr pulses twice, with (0x10,0x5A) then (0x11,0xC3); reg_addr=0x12 after STOP; busy falls on STOP.
- Random read: START, 0xA0, 0x20, repeated START, 0xA1, read 3 bytes ACK/ACK/NACK, STOP, with user regs[i]=i^0xFF → master receives 0xDF, 0xDE, 0xDD; 3 reg_rd pulses; SDA released after the NACK.
- Address mismatch: START, 0xB0, data, STOP → sda_oe never asserted, no reg_wr/reg_rd, busy stays 0.
- Wrap: pointer write 0xFF then two data bytes 0x11, 0x22 → writes land at 0xFF then 0x00.
- Abort: START mid-way through a data byte (after 4 bits) → no reg_wr, sda_oe=0, next address byte decoded normally.
- Reset: rstn low while driving a read bit 0 → sda_oe=0 asynchronously; all outputs at reset values; next transaction works.

Source files
------------

// File: rtl/i2c_slave_regs.sv
// I2C target with a byte-wide register port: pointer write, then auto-incrementing
// data writes/reads. SCL/SDA are oversampled on clk; SDA is driven open-drain via sda_oe.
`timescale 1ns/1ps
module i2c_slave_regs #(
   parameter logic [6:0]  SLAVE_ADDR = 7'h50,
   parameter int unsigned AW         = 8
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          scl_i,
   input  logic          sda_i,
   output logic          sda_oe,
   output logic [AW-1:0] reg_addr,
   output logic          reg_wr,
   output logic [7:0]    reg_wdata,
   output logic          reg_rd,
   input  logic [7:0]    reg_rdata,
   output logic          busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
   } state_e;

   // [0],[1] synchronizer, [2] history; the idle bus is high
   logic [2:0]    scl_sync_q, sda_sync_q;
   state_e        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          rw_q, rw_d;
   logic          first_q, first_d;
   logic          sda_oe_q, sda_oe_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          wr_q, wr_d;
   logic [7:0]    wdata_q, wdata_d;
   logic          busy_q, busy_d;

   logic scl_s, scl_h, sda_s, sda_h;
   logic scl_rise, scl_fall, start_c, stop_c;
   logic [7:0] byte_in;

   assign scl_s    = scl_sync_q[1];
   assign scl_h    = scl_sync_q[2];
   assign sda_s    = sda_sync_q[1];
   assign sda_h    = sda_sync_q[2];
   assign scl_rise = scl_s & ~scl_h;
   assign scl_fall = ~scl_s & scl_h;
   assign start_c  = scl_s & scl_h & sda_h & ~sda_s;
   assign stop_c   = scl_s & scl_h & ~sda_h & sda_s;
   assign byte_in  = {shift_q[6:0], sda_s};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         scl_sync_q <= 3'b111;
         sda_sync_q <= 3'b111;
         state_q    <= S_IDLE;
         cnt_q      <= 3'd0;
         shift_q    <= 8'h00;
         rw_q       <= 1'b0;
         first_q    <= 1'b0;
         sda_oe_q   <= 1'b0;
         addr_q     <= '0;
         wr_q       <= 1'b0;
         wdata_q    <= 8'h00;
         busy_q     <= 1'b0;
      end else begin
         scl_sync_q <= {scl_sync_q[1:0], scl_i};
         sda_sync_q <= {sda_sync_q[1:0], sda_i};
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         rw_q       <= rw_d;
         first_q    <= first_d;
         sda_oe_q   <= sda_oe_d;
         addr_q     <= addr_d;
         wr_q       <= wr_d;
         wdata_q    <= wdata_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      rw_d     = rw_q;
      first_d  = first_q;
      sda_oe_d = sda_oe_q;
      addr_d   = addr_q;
      wr_d     = 1'b0;
      wdata_d  = wdata_q;
      busy_d   = busy_q;
      reg_rd   = 1'b0;
      // The pointer advances the clk after each write strobe
      if (wr_q) addr_d = addr_q + AW'(1);
      if (start_c) begin
         state_d  = S_ADDR;
         cnt_d    = 3'd0;
         sda_oe_d = 1'b0;
      end else if (stop_c) begin
         state_d  = S_IDLE;
         busy_d   = 1'b0;
         sda_oe_d = 1'b0;
      end else begin
         case (state_q)
            S_ADDR: if (scl_rise) begin
               shift_d = byte_in;
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  cnt_d = 3'd0;
                  if (byte_in[7:1] == SLAVE_ADDR) begin
                     state_d = S_ADDR_ACK;
                     busy_d  = 1'b1;
                     rw_d    = byte_in[0];
                  end else begin
                     state_d = S_IGNORE;
                     busy_d  = 1'b0;
                  end
               end
            end
            // cnt_q==0: fall after bit 8 starts the ACK; cnt_q==1: fall after bit 9 ends it
            S_ADDR_ACK, S_WR_ACK: if (scl_fall) begin
               if (cnt_q == 3'd0) begin
                  sda_oe_d = 1'b1;
                  cnt_d    = 3'd1;
               end else begin
                  sda_oe_d = 1'b0;
                  cnt_d    = 3'd0;
                  if (state_q == S_WR_ACK || !rw_q) begin
                     state_d = S_WR_BYTE;
                     if (state_q == S_ADDR_ACK) first_d = 1'b1;
                  end else begin
                     reg_rd   = 1'b1;
                     sda_oe_d = ~reg_rdata[7];
                     shift_d  = {reg_rdata[6:0], 1'b0};
                     state_d  = S_RD_BYTE;
                  end
               end
            end
            S_WR_BYTE: if (scl_rise) begin
               shift_d = byte_in;
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  cnt_d   = 3'd0;
                  state_d = S_WR_ACK;
                  if (first_q) begin
                     addr_d  = AW'(byte_in);
                     first_d = 1'b0;
                  end else begin
                     wdata_d = byte_in;
                     wr_d    = 1'b1;
                  end
               end
            end
            S_RD_BYTE: if (scl_fall) begin
               if (cnt_q == 3'd7) begin
                  sda_oe_d = 1'b0;
                  addr_d   = addr_q + AW'(1);
                  cnt_d    = 3'd0;
                  state_d  = S_RD_ACK;
               end else begin
                  sda_oe_d = ~shift_q[7];
                  shift_d  = {shift_q[6:0], 1'b0};
                  cnt_d    = cnt_q + 3'd1;
               end
            end
            S_RD_ACK: begin
               if (scl_rise && sda_s) begin
                  state_d = S_IGNORE;
                  busy_d  = 1'b0;
               end else if (scl_fall) begin
                  reg_rd   = 1'b1;
                  sda_oe_d = ~reg_rdata[7];
                  shift_d  = {reg_rdata[6:0], 1'b0};
                  cnt_d    = 3'd0;
                  state_d  = S_RD_BYTE;
               end
            end
            default: ;
         endcase
      end
   end

   assign sda_oe    = sda_oe_q;
   assign reg_addr  = addr_q;
   assign reg_wr    = wr_q;
   assign reg_wdata = wdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-banged I2C master on a wired-AND SDA line
// and a register file model where regs[i] = i ^ 0xFF.
`timescale 1ns/1ps
module tb_i2c_slave_regs;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_line;
   logic       sda_oe;
   logic [7:0] reg_addr;
   logic       reg_wr;
   logic [7:0] reg_wdata;
   logic       reg_rd;
   logic [7:0] reg_rdata;
   logic       busy;

   assign sda_line  = sda_m & ~sda_oe;
   assign reg_rdata = reg_addr ^ 8'hFF;

   i2c_slave_regs #(.SLAVE_ADDR(7'h50), .AW(8)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .scl_i     (scl_m),
      .sda_i     (sda_line),
      .sda_oe    (sda_oe),
      .reg_addr  (reg_addr),
      .reg_wr    (reg_wr),
      .reg_wdata (reg_wdata),
      .reg_rd    (reg_rd),
      .reg_rdata (reg_rdata),
      .busy      (busy)
   );

   always #10 clk = ~clk;

   int          q = 10;
   int          n_chk = 0;
   int          n_err = 0;
   logic [15:0] wr_log[$];
   int          rd_cnt = 0;
   logic        oe_seen = 1'b0;
   logic        busy_seen = 1'b0;
   int          wr_long = 0;
   int          wr_inc_err = 0;
   logic        prev_wr = 1'b0;
   logic [7:0]  prev_addr = 8'h00;

   always @(negedge clk) begin
      if (reg_wr) wr_log.push_back({reg_addr, reg_wdata});
      if (reg_rd) rd_cnt++;
      if (sda_oe) oe_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
      if (reg_wr && prev_wr) wr_long++;
      if (prev_wr && rstn && (reg_addr !== prev_addr + 8'd1)) wr_inc_err++;
      prev_wr   = reg_wr;
      prev_addr = reg_addr;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic wq();
      repeat (q) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wq();
      scl_m = 1'b1; wq();
      sda_m = 1'b0; wq();
      scl_m = 1'b0; wq();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wq();
      scl_m = 1'b1; wq();
      sda_m = 1'b1; wq();
   endtask

   task automatic wbit(input logic b);
      sda_m = b;    wq();
      scl_m = 1'b1; wq(); wq();
      scl_m = 1'b0; wq();
   endtask

   task automatic rbit(output logic b);
      sda_m = 1'b1; wq();
      scl_m = 1'b1; wq();
      b = sda_line; wq();
      scl_m = 1'b0; wq();
   endtask

   task automatic wbyte(input logic [7:0] d, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) wbit(d[i]);
      rbit(b);
      ack = ~b;
   endtask

   task automatic rbyte(output logic [7:0] d, input logic nack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         rbit(b);
         d[i] = b;
      end
      wbit(nack);
   endtask

   typedef struct {
      int         qq;
      logic [7:0] ptr, d0, d1;
      logic [7:0] a0, a1, fin;
   } wvec_t;

   initial begin
      wvec_t      tv[3];
      logic       ack;
      logic [7:0] d;

      tv[0] = '{125, 8'h10, 8'h5A, 8'hC3, 8'h10, 8'h11, 8'h12};
      tv[1] = '{10,  8'hFF, 8'h11, 8'h22, 8'hFF, 8'h00, 8'h01};
      tv[2] = '{10,  8'h7F, 8'h00, 8'hFF, 8'h7F, 8'h80, 8'h81};

      // Reset state
      repeat (5) @(negedge clk);
      chk("rst sda_oe", sda_oe, 0);
      chk("rst reg_addr", reg_addr, 0);
      chk("rst reg_wr", reg_wr, 0);
      chk("rst reg_rd", reg_rd, 0);
      chk("rst busy", busy, 0);
      chk("rst reg_wdata", reg_wdata, 0);
      rstn = 1'b1;
      repeat (20) @(negedge clk);

      // Write transactions: pointer then two data bytes
      for (int i = 0; i < 3; i++) begin
         q = tv[i].qq;
         wr_log.delete();
         i2c_start();
         wbyte(8'hA0, ack);     chk("wr addr ack", ack, 1);
         chk("busy after match", busy, 1);
         wbyte(tv[i].ptr, ack); chk("wr ptr ack", ack, 1);
         wbyte(tv[i].d0, ack);  chk("wr d0 ack", ack, 1);
         wbyte(tv[i].d1, ack);  chk("wr d1 ack", ack, 1);
         chk("busy before stop", busy, 1);
         i2c_stop();
         chk("busy after stop", busy, 0);
         chk("wr count", wr_log.size(), 2);
         if (wr_log.size() == 2) begin
            chk("wr entry0", wr_log[0], {tv[i].a0, tv[i].d0});
            chk("wr entry1", wr_log[1], {tv[i].a1, tv[i].d1});
         end
         chk("final ptr", reg_addr, tv[i].fin);
         repeat (4 * q) @(negedge clk);
      end
      q = 10;

      // Random read: pointer write, repeated START, three reads
      wr_log.delete();
      rd_cnt = 0;
      i2c_start();
      wbyte(8'hA0, ack); chk("rd waddr ack", ack, 1);
      wbyte(8'h20, ack); chk("rd ptr ack", ack, 1);
      i2c_start();
      wbyte(8'hA1, ack); chk("rd raddr ack", ack, 1);
      rbyte(d, 1'b0);    chk("rd byte0", d, 8'hDF);
      rbyte(d, 1'b0);    chk("rd byte1", d, 8'hDE);
      rbyte(d, 1'b1);    chk("rd byte2", d, 8'hDD);
      chk("sda released after nack", sda_oe, 0);
      chk("busy after nack", busy, 0);
      oe_seen = 1'b0;
      i2c_stop();
      chk("no drive after nack", oe_seen, 0);
      chk("rd strobe count", rd_cnt, 3);
      chk("rd final ptr", reg_addr, 8'h23);
      chk("rd no writes", wr_log.size(), 0);
      repeat (4 * q) @(negedge clk);

      // Address mismatch
      wr_log.delete();
      rd_cnt = 0;
      oe_seen = 1'b0;
      busy_seen = 1'b0;
      i2c_start();
      wbyte(8'hB0, ack); chk("mis addr nack", ack, 0);
      wbyte(8'h55, ack); chk("mis data nack", ack, 0);
      i2c_stop();
      chk("mis sda_oe seen", oe_seen, 0);
      chk("mis busy seen", busy_seen, 0);
      chk("mis writes", wr_log.size(), 0);
      chk("mis reads", rd_cnt, 0);
      repeat (4 * q) @(negedge clk);

      // START after 4 bits of a data byte aborts it
      wr_log.delete();
      i2c_start();
      wbyte(8'hA0, ack); chk("abort addr ack", ack, 1);
      wbyte(8'h40, ack); chk("abort ptr ack", ack, 1);
      for (int i = 0; i < 4; i++) wbit(1'b1);
      i2c_start();
      chk("abort sda_oe", sda_oe, 0);
      chk("abort no write", wr_log.size(), 0);
      wbyte(8'hA0, ack); chk("after abort addr ack", ack, 1);
      wbyte(8'h41, ack); chk("after abort ptr ack", ack, 1);
      wbyte(8'h99, ack); chk("after abort data ack", ack, 1);
      i2c_stop();
      chk("abort write count", wr_log.size(), 1);
      if (wr_log.size() == 1) chk("abort entry", wr_log[0], 16'h4199);
      chk("abort final ptr", reg_addr, 8'h42);
      repeat (4 * q) @(negedge clk);

      // Reset while the target drives a 0 read bit
      i2c_start();
      wbyte(8'hA0, ack); chk("rst-seq addr ack", ack, 1);
      wbyte(8'h80, ack); chk("rst-seq ptr ack", ack, 1);
      i2c_start();
      wbyte(8'hA1, ack); chk("rst-seq raddr ack", ack, 1);
      chk("driving read bit0", sda_oe, 1);
      #3 rstn = 1'b0;
      #1;
      chk("async rst sda_oe", sda_oe, 0);
      chk("async rst reg_addr", reg_addr, 0);
      chk("async rst busy", busy, 0);
      chk("async rst reg_wr", reg_wr, 0);
      chk("async rst reg_rd", reg_rd, 0);
      chk("async rst reg_wdata", reg_wdata, 0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (4) @(negedge clk);
      i2c_stop();
      wr_log.delete();
      i2c_start();
      wbyte(8'hA0, ack); chk("post-rst addr ack", ack, 1);
      wbyte(8'h05, ack); chk("post-rst ptr ack", ack, 1);
      wbyte(8'hAB, ack); chk("post-rst data ack", ack, 1);
      i2c_stop();
      chk("post-rst write count", wr_log.size(), 1);
      if (wr_log.size() == 1) chk("post-rst entry", wr_log[0], 16'h05AB);
      chk("post-rst final ptr", reg_addr, 8'h06);

      chk("wr strobe width", wr_long, 0);
      chk("ptr inc after write", wr_inc_err, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
